// File: rtl/irrigation_sequencer_if.sv
// -----------------------------------------------------------------------------
// irrigation_sequencer_if
// Bundles the control/status signals between the top-level controller (master)
// and the irrigation valve sequencer (slave). clk and reset are not included;
// they stay plain ports on the sequencer.
//   tick            controller -> sequencer  one-cycle timing strobe
//   start           controller -> sequencer  run one irrigation cycle
//   irr_type[2:0]   controller -> sequencer  irrigation-type code
//   water_ok        controller -> sequencer  reservoir level sufficient
//   clear           controller -> sequencer  leave FAULT
//   pause           controller -> sequencer  suspend the phase (PAUSE_EN only)
//   sprinkler_valve sequencer -> controller  sprinkler valve drive
//   drip_valve      sequencer -> controller  drip valve drive
//   busy            sequencer -> controller  SPRINKLE or DRIP active
//   done            sequencer -> controller  one-cycle completion pulse
//   fault           sequencer -> controller  FAULT state
//   phase[2:0]      sequencer -> controller  state code
// Optional macro: PAUSE_EN adds the pause signal.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface irrigation_sequencer_if;
  logic       tick;
  logic       start;
  logic [2:0] irr_type;
  logic       water_ok;
  logic       clear;
`ifdef PAUSE_EN
  logic       pause;
`endif
  logic       sprinkler_valve;
  logic       drip_valve;
  logic       busy;
  logic       done;
  logic       fault;
  logic [2:0] phase;

  modport master (
    output tick, start, irr_type, water_ok, clear,
`ifdef PAUSE_EN
    output pause,
`endif
    input  sprinkler_valve, drip_valve, busy, done, fault, phase
  );

  modport slave (
    input  tick, start, irr_type, water_ok, clear,
`ifdef PAUSE_EN
    input  pause,
`endif
    output sprinkler_valve, drip_valve, busy, done, fault, phase
  );
endinterface

// File: rtl/irrigation_sequencer.sv
// -----------------------------------------------------------------------------
// irrigation_sequencer
// Drives the sprinkler and drip valves from a latched 3-bit irrigation-type
// code (001 sprinkler-then-drip, 010 drip, 100 sprinkler, 000 none). Each
// phase lasts a fixed number of tick strobes; losing water_ok while a valve
// is open forces FAULT, which is left only through clear.
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    irrigation_sequencer_if.slave (see the interface file for members)
// Parameters:
//   SPRINKLE_TICKS  sprinkler phase length in ticks
//   DRIP_TICKS      drip phase length in ticks
//   CNT_W           phase counter width, holds max(phase length)-1
// Optional macro: PAUSE_EN adds bus.pause, which closes both valves and
// freezes the phase counter while asserted in SPRINKLE or DRIP.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module irrigation_sequencer #(
  parameter int SPRINKLE_TICKS = 1350,
  parameter int DRIP_TICKS     = 1800,
  parameter int CNT_W          = 12
) (
  input  logic                          clk,
  input  logic                          reset,
  irrigation_sequencer_if.slave         bus
);

  // Encodings double as the phase output code.
  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_SPRINKLE = 3'b001,
    S_DRIP     = 3'b010,
    S_DONE     = 3'b011,
    S_FAULT    = 3'b100
  } state_t;

  localparam logic [2:0] T_NONE      = 3'b000;
  localparam logic [2:0] T_SPR_DRIP  = 3'b001;
  localparam logic [2:0] T_DRIP      = 3'b010;
  localparam logic [2:0] T_SPR       = 3'b100;

  localparam logic [CNT_W-1:0] SPR_LAST  = CNT_W'(SPRINKLE_TICKS - 1);
  localparam logic [CNT_W-1:0] DRIP_LAST = CNT_W'(DRIP_TICKS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       type_q, type_d;
  logic             spr_q, drip_q, busy_q, done_q, fault_q;
  logic             spr_d, drip_d, busy_d, done_d, fault_d;
  logic             paused;

`ifdef PAUSE_EN
  assign paused = bus.pause;
`else
  assign paused = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    type_d  = type_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          type_d = bus.irr_type;
          cnt_d  = '0;
          unique case (bus.irr_type)
            T_NONE:            state_d = S_DONE;
            T_SPR_DRIP, T_SPR: state_d = bus.water_ok ? S_SPRINKLE : S_FAULT;
            T_DRIP:            state_d = bus.water_ok ? S_DRIP     : S_FAULT;
            default:           state_d = S_FAULT;
          endcase
        end
      end

      S_SPRINKLE: begin
        // Losing water outranks a terminal tick in the same cycle.
        if (!bus.water_ok) begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end else if (bus.tick && !paused) begin
          if (cnt_q == SPR_LAST) begin
            cnt_d   = '0;
            state_d = (type_q == T_SPR_DRIP) ? S_DRIP : S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_DRIP: begin
        if (!bus.water_ok) begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end else if (bus.tick && !paused) begin
          if (cnt_q == DRIP_LAST) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_DONE:  state_d = S_IDLE;

      S_FAULT: if (bus.clear) state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register on the same edge
  // as the state itself; the handover edge thus drops sprinkler and raises drip
  // together.
  always_comb begin
    spr_d   = (state_d == S_SPRINKLE) && !paused;
    drip_d  = (state_d == S_DRIP) && !paused;
    busy_d  = (state_d == S_SPRINKLE) || (state_d == S_DRIP);
    done_d  = (state_d == S_DONE);
    fault_d = (state_d == S_FAULT);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      type_q  <= T_NONE;
      spr_q   <= 1'b0;
      drip_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      spr_q   <= spr_d;
      drip_q  <= drip_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  assign bus.sprinkler_valve = spr_q;
  assign bus.drip_valve      = drip_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.fault           = fault_q;
  assign bus.phase           = state_q;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// -----------------------------------------------------------------------------
// tb_irrigation_sequencer
// Directed bench for irrigation_sequencer with short phases
// (SPRINKLE_TICKS=4, DRIP_TICKS=3). A table of per-cycle input/expected-output
// rows is applied first, then hand-written sequences cover irregular tick
// spacing and, when PAUSE_EN is defined, the pause behaviour.
// Expected outputs are packed as {sprinkler, drip, busy, done, fault, phase}.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_irrigation_sequencer;

  localparam int SPR_T  = 4;
  localparam int DRIP_T = 3;

  localparam logic [7:0] O_IDLE  = 8'b00000_000;
  localparam logic [7:0] O_SPR   = 8'b10100_001;
  localparam logic [7:0] O_DRIP  = 8'b01100_010;
  localparam logic [7:0] O_DONE  = 8'b00010_011;
  localparam logic [7:0] O_FAULT = 8'b00001_100;
  localparam logic [7:0] O_PAUSE = 8'b00100_001;

  typedef struct {
    logic       rst;
    logic       tick;
    logic       start;
    logic [2:0] irr_type;
    logic       water_ok;
    logic       clear;
    logic [7:0] exp;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t vecs[$];

  irrigation_sequencer_if bus ();

  irrigation_sequencer #(
    .SPRINKLE_TICKS (SPR_T),
    .DRIP_TICKS     (DRIP_T),
    .CNT_W          (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {bus.sprinkler_valve, bus.drip_valve, bus.busy, bus.done, bus.fault,
            bus.phase};
  endfunction

  task automatic check(input string name, input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b expected=%b", name, got, exp);
    end
  endtask

  task automatic add(input logic rst, input logic tick, input logic start,
                     input logic [2:0] ty, input logic wok, input logic clr,
                     input logic [7:0] exp);
    vec_t v;
    v.rst = rst; v.tick = tick; v.start = start; v.irr_type = ty;
    v.water_ok = wok; v.clear = clr; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic tick, input logic start,
                       input logic [2:0] ty, input logic wok, input logic clr);
    reset        = rst;
    bus.tick     = tick;
    bus.start    = start;
    bus.irr_type = ty;
    bus.water_ok = wok;
    bus.clear    = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
`ifdef PAUSE_EN
    bus.pause = 1'b0;
`endif

    //  rst tick start type  wok clr  expected
    add(1, 0, 0, 3'b000, 1, 0, O_IDLE);   // reset state
    add(0, 0, 0, 3'b000, 1, 0, O_IDLE);
    add(0, 0, 1, 3'b100, 1, 0, O_SPR);    // sprinkler only, 1-cycle latency
    add(0, 1, 0, 3'b100, 1, 0, O_SPR);    // tick 1
    add(0, 0, 0, 3'b100, 1, 0, O_SPR);
    add(0, 1, 0, 3'b000, 1, 0, O_SPR);    // tick 2, irr_type change ignored
    add(0, 1, 0, 3'b100, 1, 0, O_SPR);    // tick 3
    add(0, 1, 1, 3'b010, 1, 0, O_DONE);   // tick 4 terminal, start ignored
    add(0, 0, 1, 3'b001, 1, 0, O_IDLE);   // start ignored in DONE
    add(0, 0, 1, 3'b001, 1, 0, O_SPR);    // sprinkler-then-drip
    add(0, 1, 0, 3'b001, 1, 0, O_SPR);
    add(0, 1, 0, 3'b001, 1, 0, O_SPR);
    add(0, 1, 0, 3'b001, 1, 0, O_SPR);
    add(0, 1, 0, 3'b001, 1, 0, O_DRIP);   // handover edge
    add(0, 1, 0, 3'b001, 1, 0, O_DRIP);
    add(0, 1, 0, 3'b001, 1, 0, O_DRIP);
    add(0, 1, 0, 3'b001, 1, 0, O_DONE);   // 3rd drip tick terminal
    add(0, 0, 0, 3'b000, 1, 0, O_IDLE);
    add(0, 0, 1, 3'b010, 1, 0, O_DRIP);   // drip only
    add(0, 1, 0, 3'b010, 1, 0, O_DRIP);
    add(0, 0, 0, 3'b010, 0, 0, O_FAULT);  // water lost mid-drip
    add(0, 0, 1, 3'b100, 1, 0, O_FAULT);  // held without clear
    add(0, 0, 0, 3'b000, 1, 1, O_IDLE);   // clear
    add(0, 0, 1, 3'b000, 0, 0, O_DONE);   // none: DONE regardless of water
    add(0, 0, 0, 3'b000, 1, 0, O_IDLE);
    add(0, 0, 1, 3'b110, 1, 0, O_FAULT);  // invalid code
    add(0, 0, 0, 3'b000, 1, 1, O_IDLE);
    add(0, 0, 1, 3'b100, 0, 0, O_FAULT);  // valid code but no water
    add(0, 0, 0, 3'b000, 1, 1, O_IDLE);
    add(0, 0, 0, 3'b000, 1, 1, O_IDLE);   // clear ignored in IDLE
    add(0, 0, 1, 3'b010, 1, 0, O_DRIP);
    add(0, 1, 0, 3'b010, 1, 0, O_DRIP);
    add(1, 1, 1, 3'b010, 1, 0, O_IDLE);   // reset mid-drip
    add(0, 0, 1, 3'b010, 1, 0, O_DRIP);   // counter restarts from 0
    add(0, 1, 0, 3'b010, 1, 0, O_DRIP);
    add(0, 1, 0, 3'b010, 1, 0, O_DRIP);
    add(0, 1, 0, 3'b010, 0, 0, O_FAULT);  // terminal tick with water lost
    add(0, 0, 0, 3'b000, 1, 1, O_IDLE);
    add(0, 0, 1, 3'b111, 1, 0, O_FAULT);  // invalid code
    add(0, 0, 0, 3'b000, 1, 1, O_IDLE);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].tick, vecs[i].start, vecs[i].irr_type,
            vecs[i].water_ok, vecs[i].clear);
      step();
      check($sformatf("row%0d", i), outs(), vecs[i].exp);
      check($sformatf("row%0d_one_valve", i),
            {7'b0, bus.sprinkler_valve & bus.drip_valve}, 8'd0);
    end

    // Irregular tick spacing: the sprinkler phase must last exactly SPR_T
    // ticks, with done appearing on the edge of the last one.
    begin
      int  ticks_sent;
      int  ticks_at_done;
      bit  seen_done;
      ticks_sent    = 0;
      ticks_at_done = -1;
      seen_done     = 1'b0;
      drive(1'b0, 1'b0, 1'b1, 3'b100, 1'b1, 1'b0);
      step();
      check("irr_start", outs(), O_SPR);
      for (int i = 0; i < 60 && !seen_done; i++) begin
        drive(1'b0, (i % 3) == 2, 1'b0, 3'b000, 1'b1, 1'b0);
        if ((i % 3) == 2) ticks_sent++;
        step();
        if (bus.done) begin
          seen_done     = 1'b1;
          ticks_at_done = ticks_sent;
        end else begin
          check($sformatf("irr_hold%0d", i), outs(), O_SPR);
        end
      end
      check("irr_done_seen", {7'b0, seen_done}, 8'd1);
      check("irr_tick_count", 8'(ticks_at_done), 8'(SPR_T));
      drive(1'b0, 1'b1, 1'b1, 3'b100, 1'b1, 1'b0);
      step();
      check("irr_done_one_cycle", outs(), O_IDLE);
    end

`ifdef PAUSE_EN
    // Pause at counter 2 for 5 ticks; exactly 2 more ticks finish the phase.
    drive(1'b0, 1'b0, 1'b1, 3'b100, 1'b1, 1'b0);
    step();
    check("pause_start", outs(), O_SPR);
    drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0);
    step();
    step();
    check("pause_cnt2", outs(), O_SPR);
    bus.pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("pause_hold%0d", i), outs(), O_PAUSE);
    end
    bus.pause = 1'b0;
    bus.tick  = 1'b0;
    step();
    check("pause_release", outs(), O_SPR);
    bus.tick = 1'b1;
    step();
    check("pause_tick3", outs(), O_SPR);
    step();
    check("pause_tick4_done", outs(), O_DONE);
    bus.tick = 1'b0;
    step();
    check("pause_idle", outs(), O_IDLE);

    // Water lost while paused still faults.
    drive(1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0);
    step();
    bus.start = 1'b0;
    bus.pause = 1'b1;
    step();
    check("pause_drip_closed", outs(), 8'b00100_010);
    bus.water_ok = 1'b0;
    step();
    check("pause_water_fault", outs(), O_FAULT);
    bus.pause    = 1'b0;
    bus.water_ok = 1'b1;
    bus.clear    = 1'b1;
    step();
    check("pause_clear", outs(), O_IDLE);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irrigation_sequencer.md
Name: irrigation_sequencer

Overview:
Sequences the irrigation valves from the 3-bit irrigation-type code produced by the irrigation-state classifier: 001 sprinkler-then-drip, 010 drip only, 100 sprinkler only, 000 no irrigation. It times each phase with a tick strobe, interlocks on water availability, and reports busy/done/fault to the top-level controller. It sits between the classifier flip-flops and the valve drivers.

Parameters:
SPRINKLE_TICKS, 1350, sprinkler phase length in ticks (22 min 30 s at a 1 Hz tick)
DRIP_TICKS, 1800, drip phase length in ticks
CNT_W, 12, phase counter width; must hold max(SPRINKLE_TICKS, DRIP_TICKS)-1

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
tick  in  1  one-cycle timing strobe, 1 Hz nominal
start  in  1  request to run one irrigation cycle; sampled only in IDLE
irr_type  in  3  irrigation-type code, sampled with start
water_ok  in  1  1 = reservoir level sufficient
clear  in  1  leaves FAULT
sprinkler_valve  out  1  sprinkler valve drive
drip_valve  out  1  drip valve drive
busy  out  1  high in SPRINKLE or DRIP
done  out  1  one-cycle pulse when a cycle completes
fault  out  1  high in FAULT
phase  out  3  state code: 000 IDLE, 001 SPRINKLE, 010 DRIP, 011 DONE, 100 FAULT

Behaviour:
- Clock is one clock, clk. Reset is synchronous and active-high on reset. Reset forces IDLE, counter 0, latched type 000, and all outputs 0. Reset has priority over every other input, including mid-phase. Valves close on the edge where reset is sampled.
- Moore outputs, registered from state: sprinkler_valve=1 only in SPRINKLE, drip_valve=1 only in DRIP, busy=1 in SPRINKLE or DRIP, fault=1 only in FAULT. done=1 only during the single cycle in DONE.
- IDLE: when start=1, latch irr_type and decode at the next edge:
  - 100 or 001 with water_ok=1 -> SPRINKLE
  - 010 with water_ok=1 -> DRIP
  - 000 -> DONE (no valve activity, regardless of water_ok)
  - any other code (011, 101, 110, 111) -> FAULT
  - a valid non-zero code with water_ok=0 -> FAULT
- The valve output rises on the edge after start is sampled, giving 1-cycle latency.
- SPRINKLE:
  - Counter starts at 0 on entry and increments on each tick.
  - On the tick where counter == SPRINKLE_TICKS-1: latched 001 -> DRIP with counter cleared; latched 100 -> DONE.
  - The sprinkler-to-drip handover is gap-free and overlap-free: sprinkler falls and drip rises on the same edge.
- DRIP: same counting rule with DRIP_TICKS; on the terminal tick -> DONE.
- water_ok=0 in SPRINKLE or DRIP -> FAULT on the next edge, valves closed. This has priority over a terminal tick in the same cycle.
- DONE: one cycle, then IDLE. start is ignored in DONE.
- FAULT: held until clear=1, then IDLE on the next edge. clear is ignored in every other state.
- start, irr_type and clear outside their sampling states are ignored; irr_type changes mid-cycle have no effect.
- tick only advances the counter in SPRINKLE and DRIP. The counter never wraps: the terminal compare always exits the state first.
- Only one valve is ever open at a time, in every state.

Optional Feature:
PAUSE_EN:
- Defined:
  - Adds input port pause (1 bit).
  - While pause=1 in SPRINKLE or DRIP, both valves are 0, ticks are not counted, and the state and counter hold.
  - On pause release the same valve reopens on the next edge and counting resumes from the held value.
  - busy stays 1 while paused.
  - water_ok=0 during a pause still forces FAULT.
- Undefined: the pause port does not exist and counting is never suspended.

Test Plan:
- Reset, then start=1, irr_type=100, water_ok=1, SPRINKLE_TICKS=4 -> sprinkler_valve=1 one edge later; after 4 ticks done pulses for 1 cycle; phase returns to 000.
- irr_type=001, SPRINKLE_TICKS=3, DRIP_TICKS=2 -> sprinkler on for 3 ticks, drip on for 2 ticks; on the handover edge sprinkler falls and drip rises together; the two valves are never both 1.
- irr_type=010 with water_ok dropping after tick 1 -> FAULT next edge, drip_valve=0, fault=1; clear=1 -> IDLE.
- irr_type=000 -> DONE with no valve activity; irr_type=110 -> FAULT.
- Assert reset mid-DRIP -> all outputs 0 next edge, phase=000; a terminal tick coincident with water_ok=0 -> FAULT, not DONE.
- With PAUSE_EN: pause for 5 ticks mid-SPRINKLE with SPRINKLE_TICKS=4 at counter 2 -> valves 0, counter held at 2; after release, exactly 2 more ticks complete the phase.
